// File: rtl/ascii_case_restorer.sv
// ascii_case_restorer: undoes the ASCII case conversion from a (char, cap) pair and
// queues the restored character in a valid/ready FIFO with saturating statistics.
module ascii_case_restorer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:7]       in_char,
    input  logic             in_cap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:7]       out_char,
    output logic             out_err,
    output logic [CNT_W-1:0] char_cnt,
    output logic [CNT_W-1:0] cap_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [8:0]  mem [DEPTH];
    logic [7:0]  c, restored;
    logic        err, push, pop, full, empty;

    assign c        = in_char;
    assign restored = in_cap ? c - 8'd32 : c + 8'd32;
    assign err      = in_cap ? (c < 8'd32 || c >= 8'd129) : (c < 8'd65 || c > 8'd223);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = wr_ptr == rd_ptr;
    assign in_ready = !full;
    assign out_valid = !empty;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // Entry RAM is never reset, so the head is masked while the FIFO is empty.
    assign out_char = out_valid ? mem[rd_ptr[AW-1:0]][8:1] : 8'h00;
    assign out_err  = out_valid && mem[rd_ptr[AW-1:0]][0];

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[AW-1:0]] <= {restored, err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            char_cnt <= '0;
            cap_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && char_cnt != '1) char_cnt <= char_cnt + 1'b1;
            if (push && in_cap && cap_cnt != '1) cap_cnt <= cap_cnt + 1'b1;
            if (push && err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ascii_case_restorer.sv
// tb_ascii_case_restorer: directed vectors plus fill, stream and reset sequences.
module tb_ascii_case_restorer;
    logic        clk = 0, rst = 1, in_valid = 0, in_cap = 0, out_ready = 0;
    logic [0:7]  in_char = 8'h00;
    logic        in_ready, out_valid, out_err;
    logic [0:7]  out_char;
    logic [15:0] char_cnt, cap_cnt, err_cnt;
    int tests = 0, fails = 0;
    int nc = 0, ncap = 0, nerr = 0;

    typedef struct {
        logic [7:0] c;
        logic       cap;
        logic [7:0] r;
        logic       e;
    } vec_t;
    vec_t v[12];

    ascii_case_restorer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_cap(in_cap), .out_valid(out_valid),
        .out_ready(out_ready), .out_char(out_char), .out_err(out_err),
        .char_cnt(char_cnt), .cap_cnt(cap_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push_hold(input logic [7:0] ch, input logic cp);
        in_valid = 1;
        in_char  = ch;
        in_cap   = cp;
        tick();
        in_valid = 0;
    endtask

    task automatic chk_cnt(input string name, input int a, input int b, input int e);
        chk({name, " char_cnt"}, int'(char_cnt), a);
        chk({name, " cap_cnt"}, int'(cap_cnt), b);
        chk({name, " err_cnt"}, int'(err_cnt), e);
    endtask

    initial begin
        int k, got;
        logic [7:0] q[$];
        logic [7:0] nxt;
        v[0]  = '{8'd97,  1'b1, 8'd65,  1'b0};
        v[1]  = '{8'd65,  1'b0, 8'd97,  1'b0};
        v[2]  = '{8'd20,  1'b1, 8'd244, 1'b1};
        v[3]  = '{8'd240, 1'b0, 8'd16,  1'b1};
        v[4]  = '{8'd32,  1'b1, 8'd0,   1'b0};
        v[5]  = '{8'd31,  1'b1, 8'd255, 1'b1};
        v[6]  = '{8'd128, 1'b1, 8'd96,  1'b0};
        v[7]  = '{8'd129, 1'b1, 8'd97,  1'b1};
        v[8]  = '{8'd64,  1'b0, 8'd96,  1'b1};
        v[9]  = '{8'd223, 1'b0, 8'd255, 1'b0};
        v[10] = '{8'd224, 1'b0, 8'd0,   1'b1};
        v[11] = '{8'd0,   1'b0, 8'd32,  1'b1};

        tick();
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        do_reset();
        chk("post-reset in_ready", int'(in_ready), 1);
        chk("post-reset out_valid", int'(out_valid), 0);
        chk("post-reset out_char", int'(out_char), 0);
        chk("post-reset out_err", int'(out_err), 0);
        chk_cnt("post-reset", 0, 0, 0);

        foreach (v[i]) begin
            push_hold(v[i].c, v[i].cap);
            nc++;
            if (v[i].cap) ncap++;
            if (v[i].e) nerr++;
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d out_char", i), int'(out_char), int'(v[i].r));
            chk($sformatf("vec%0d out_err", i), int'(out_err), int'(v[i].e));
            chk_cnt($sformatf("vec%0d", i), nc, ncap, nerr);
            out_ready = 1;
            tick();
            out_ready = 0;
            chk($sformatf("vec%0d popped", i), int'(out_valid), 0);
        end

        // Fill with consumer stalled, then drain; fifth pair waits for space.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill%0d in_ready", i), int'(in_ready), 1);
            push_hold(8'(65 + i), 1'b0);
        end
        chk("full in_ready", int'(in_ready), 0);
        in_valid = 1;
        in_char  = 8'd69;
        in_cap   = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d in_ready", i), int'(in_ready), 0);
            chk($sformatf("stall%0d out_char", i), int'(out_char), 97);
        end
        chk("stall char_cnt", int'(char_cnt), 4);
        out_ready = 1;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
            logic acc;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk($sformatf("drain%0d out_char", k), int'(out_char), 97 + k);
                k++;
            end
            tick();
            if (acc) in_valid = 0;
        end
        out_ready = 0;
        chk("drain count", k, 5);
        chk("drain char_cnt", int'(char_cnt), 5);
        chk("drain empty", int'(out_valid), 0);

        // Concurrent push and pop keeps occupancy at two and preserves order.
        do_reset();
        q.delete();
        for (int i = 0; i < 2; i++) begin
            push_hold(8'(65 + i), 1'b0);
            q.push_back(8'(97 + i));
        end
        in_valid  = 1;
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            nxt = 8'(70 + i);
            in_char = nxt;
            chk($sformatf("stream%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("stream%0d in_ready", i), int'(in_ready), 1);
            chk($sformatf("stream%0d out_char", i), int'(out_char), int'(q.pop_front()));
            q.push_back(nxt + 8'd32);
            tick();
        end
        in_valid = 0;
        got = 0;
        for (int cyc = 0; cyc < 10 && out_valid; cyc++) begin
            chk($sformatf("tail%0d out_char", got), int'(out_char), int'(q.pop_front()));
            got++;
            tick();
        end
        out_ready = 0;
        chk("stream occupancy", got, 2);

        // Reset mid-stream discards entries and the pair offered that cycle.
        do_reset();
        for (int i = 0; i < 3; i++) push_hold(8'(97 + i), 1'b1);
        chk("pre-rst char_cnt", int'(char_cnt), 3);
        in_valid = 1;
        in_char  = 8'd100;
        in_cap   = 1;
        rst      = 1;
        tick();
        rst      = 0;
        in_valid = 0;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst out_char", int'(out_char), 0);
        chk_cnt("midrst", 0, 0, 0);
        tick();
        chk("midrst not stored", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ascii_case_restorer.md
# ascii_case_restorer

Streaming inverse of the team's ASCII case converter: it accepts a converted character together with its `cap` flag and restores the original character. Restored characters pass through a small FIFO with valid/ready handshakes on both sides, so the block can sit between a converter-fed link and a slower consumer, for example a display or UART writer. It also flags impossible (char, cap) pairs and keeps running counts of restored characters.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: the upstream pair on `in_char`/`in_cap` is valid.
- `in_ready`  out  1: the block can accept a pair this cycle.
- `in_char`  in  [0:7]: converted character; bit 0 is the MSB.
- `in_cap`  in  1: converter flag; 1 means the original was below 97 ('a').
- `out_valid`  out  1: the FIFO head is valid.
- `out_ready`  in  1: the consumer takes the head this cycle.
- `out_char`  out  [0:7]: restored original character; bit 0 is the MSB.
- `out_err`  out  1: the head entry came from an impossible pair.
- `char_cnt`  out  CNT_W: number of pairs accepted since reset.
- `cap_cnt`  out  CNT_W: number of accepted pairs with `in_cap`=1.
- `err_cnt`  out  CNT_W: number of accepted pairs flagged as errors.

## Operation
- Accept: a pair is accepted on a rising edge where `in_valid` and `in_ready` are both 1.
- Restore rule, applied at accept time. All arithmetic is 8-bit modulo 256.
  - `in_cap`=1: restored = `in_char` - 32. The pair is an error if `in_char` < 32 or `in_char` >= 129, because the original must have been < 97.
  - `in_cap`=0: restored = `in_char` + 32. The pair is an error if `in_char` < 65 or `in_char` > 223, because the original must have been 97..255.
  - An error pair still stores the wrapped restored value, with err=1.
- FIFO: `DEPTH` entries of {restored[7:0], err}.
  - Write and read pointers are log2(DEPTH)+1 bits wide and wrap at 2*DEPTH.
  - Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Flow control:
  - `in_ready` = not full. It is registered-state derived and does not depend combinationally on `out_ready`.
  - `out_valid` = not empty. `out_char`/`out_err` show the head entry and stay stable while `out_valid`=1 and `out_ready`=0.
  - A pop occurs on an edge with `out_valid`=1 and `out_ready`=1.
- Simultaneous push and pop:
  - Not full and not empty: both happen and occupancy is unchanged.
  - Full: no push happens, since `in_ready`=0; the pop proceeds and `in_ready` rises the next cycle.
  - Empty: no pop; the pushed entry appears the next cycle. There is no same-cycle bypass.
- Counters:
  - Each counter increments on an accept when its condition holds.
  - Each saturates at all-ones and does not wrap.
  - Counters are cleared only by `rst`.
- Reset (`rst`=1 at an edge):
  - Pointers go to 0 and the FIFO empties; all counters go to 0.
  - This applies even mid-stream. In-flight entries are discarded and the accept in that cycle is ignored.
  - During and after reset, `in_ready` reads 1 and `out_valid` reads 0.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_char`=8'h00 and `out_err`=0 while empty. The entry RAM is not reset; the outputs are masked with `out_valid`.
  - `char_cnt`=`cap_cnt`=`err_cnt`=0.
- Latency: a pair accepted at edge N, into an empty FIFO, is visible on `out_char` with `out_valid`=1 after edge N, in cycle N+1.
- Throughput: one pair per cycle sustained when `out_ready` is held at 1.
- Counters update at the same edge as the accept and are visible in the next cycle.
- `in_ready` falls in the cycle after the push that fills the FIFO.

## Test plan
- Restore with cap set: reset, then push ('A'+32=97, cap=1). `out_char`=65 one cycle later, `out_err`=0, `cap_cnt`=1, `char_cnt`=1.
- Restore with cap clear: push (65, cap=0). `out_char`=97 ('a'), `out_err`=0.
- Error cases:
  - Push (20, cap=1): `out_char`=244, `out_err`=1, `err_cnt`=1.
  - Push (240, cap=0): `out_char`=16, `out_err`=1, `err_cnt`=2.
- Fill and backpressure: hold `out_ready`=0 and push 5 pairs with DEPTH=4.
  - `in_ready` drops after the 4th accept, and the 5th pair is held by upstream.
  - Then raise `out_ready`: the 4 entries drain in order, the 5th is accepted, and outputs are stable while stalled.
- Simultaneous push and pop: with 2 entries queued and both handshakes active for 10 cycles, occupancy stays 2 and the order is preserved.
- Reset mid-stream: with 3 entries queued, assert `rst` for one cycle with `in_valid`=1.
  - Next cycle: `out_valid`=0, `in_ready`=1, all counters are 0.
  - That cycle's pair is not stored.
